frame_aligner_gen: RTL and testbench

Parametrised next-generation byte-stream frame aligner. Hunts two configurable 2-byte header patterns in a qualified receive byte stream, tracks payload position, and declares lock after LOCK_CNT consecutive back-to-back complete frames. Drops lock after UNLOCK_CNT non-aligned bytes. Forwards aligned payload as a registered stream with start/end markers, frame type and saturating statistics. Sits between the byte deserializer and the frame consumer.

---
 rtl/frame_aligner_gen.sv | 172 +++++++++++++++++
 tb/tb_frame_aligner_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frame_aligner_gen.sv
// Byte-stream frame aligner: hunts two 2-byte headers, tracks payload position,
// manages lock/unlock and forwards aligned payload with markers and statistics.
module frame_aligner_gen #(
    parameter int                  DATA_W        = 8,
    parameter int                  PAYLOAD_LEN   = 10,
    parameter int                  LOCK_CNT      = 3,
    parameter int                  UNLOCK_CNT    = 48,
    parameter logic [2*DATA_W-1:0] HDR_A         = 16'hAFAA,
    parameter logic [2*DATA_W-1:0] HDR_B         = 16'hBA55,
    parameter bit                  PASS_UNLOCKED = 1'b0,
    parameter int                  CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_type,
    output logic              frame_detect,
    output logic [7:0]        fr_byte_position,
    output logic [CNT_W-1:0]  good_frame_cnt,
    output logic [CNT_W-1:0]  lost_lock_cnt
);

    localparam logic [DATA_W-1:0] A_LSB      = HDR_A[DATA_W-1:0];
    localparam logic [DATA_W-1:0] A_MSB      = HDR_A[2*DATA_W-1:DATA_W];
    localparam logic [DATA_W-1:0] B_LSB      = HDR_B[DATA_W-1:0];
    localparam logic [DATA_W-1:0] B_MSB      = HDR_B[2*DATA_W-1:DATA_W];
    localparam logic [7:0]        LAST_POS   = 8'(PAYLOAD_LEN - 1);
    localparam logic [7:0]        UNLOCK_MAX = 8'(UNLOCK_CNT);
    localparam logic [3:0]        LOCK_MAX   = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  CNT_ONE    = 1;

    typedef enum logic [1:0] {S_HUNT, S_HLSB, S_DATA} state_t;

    state_t      r_state, w_nextState;
    logic        r_type;
    logic        r_fwd;
    logic [7:0]  r_pos;
    logic [7:0]  r_naCnt;
    logic [3:0]  r_consec;

    logic        w_isPayload, w_complete, w_enterData;
    logic        w_naInc, w_consecClr, w_latchType, w_newType;
    logic        w_fwdNow, w_lockHit, w_unlockHit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_isPayload = 1'b0;
        w_complete  = 1'b0;
        w_enterData = 1'b0;
        w_naInc     = 1'b0;
        w_consecClr = 1'b0;
        w_latchType = 1'b0;
        w_newType   = r_type;
        if (rx_valid) begin
            case (r_state)
                S_HUNT: begin
                    w_naInc = 1'b1;
                    if (rx_data == A_LSB) begin
                        w_nextState = S_HLSB;
                        w_latchType = 1'b1;
                        w_newType   = 1'b0;
                    end else if (rx_data == B_LSB) begin
                        w_nextState = S_HLSB;
                        w_latchType = 1'b1;
                        w_newType   = 1'b1;
                    end else begin
                        w_consecClr = 1'b1;
                    end
                end
                S_HLSB: begin
                    if (rx_data == (r_type ? B_MSB : A_MSB)) begin
                        w_nextState = S_DATA;
                        w_enterData = 1'b1;
                    end else begin
                        // A fresh header lsb re-synchronises instead of dropping to HUNT
                        w_naInc = 1'b1;
                        if (rx_data == A_LSB) begin
                            w_latchType = 1'b1;
                            w_newType   = 1'b0;
                        end else if (rx_data == B_LSB) begin
                            w_latchType = 1'b1;
                            w_newType   = 1'b1;
                        end else begin
                            w_nextState = S_HUNT;
                            w_consecClr = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    w_isPayload = 1'b1;
                    if (r_pos == LAST_POS) begin
                        w_complete  = 1'b1;
                        w_nextState = S_HUNT;
                    end
                end
                default: w_nextState = S_HUNT;
            endcase
        end
    end

    // Forwarding is decided once per frame, using lock state as seen at payload byte 0
    assign w_fwdNow    = (r_pos == 8'd0) ? (PASS_UNLOCKED || frame_detect) : r_fwd;
    assign w_lockHit   = w_complete && (({1'b0, r_consec} + 5'd1) >= {1'b0, LOCK_MAX});
    assign w_unlockHit = w_naInc && (r_naCnt < UNLOCK_MAX) && ((r_naCnt + 8'd1) == UNLOCK_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_type           <= 1'b0;
            r_fwd            <= 1'b0;
            r_pos            <= 8'd0;
            r_naCnt          <= 8'd0;
            r_consec         <= 4'd0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_sop          <= 1'b0;
            out_eop          <= 1'b0;
            out_type         <= 1'b0;
            frame_detect     <= 1'b0;
            fr_byte_position <= 8'd0;
            good_frame_cnt   <= '0;
            lost_lock_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            if (rx_valid) begin
                fr_byte_position <= (r_state == S_DATA) ? r_pos : 8'd0;
                if (w_latchType) r_type <= w_newType;
                if (w_enterData) r_pos <= 8'd0;
                if (w_isPayload) begin
                    r_pos     <= r_pos + 8'd1;
                    out_data  <= rx_data;
                    out_valid <= w_fwdNow;
                    out_sop   <= w_fwdNow && (r_pos == 8'd0);
                    out_eop   <= w_fwdNow && w_complete;
                    if (r_pos == 8'd0) begin
                        r_fwd    <= w_fwdNow;
                        out_type <= r_type;
                    end
                end
                if (w_complete) begin
                    r_naCnt <= 8'd0;
                    if (r_consec < LOCK_MAX) r_consec <= r_consec + 4'd1;
                    if (good_frame_cnt != '1) good_frame_cnt <= good_frame_cnt + CNT_ONE;
                end else begin
                    if (w_naInc && (r_naCnt < UNLOCK_MAX)) r_naCnt <= r_naCnt + 8'd1;
                    if (w_consecClr) r_consec <= 4'd0;
                end
                if (w_lockHit) begin
                    frame_detect <= 1'b1;
                end else if (w_unlockHit) begin
                    frame_detect <= 1'b0;
                    if (frame_detect && (lost_lock_cnt != '1)) lost_lock_cnt <= lost_lock_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_aligner_gen.sv
// Directed bench for frame_aligner_gen with default parameters: reset, lock,
// gaps, re-sync, unlock, consec clearing and mid-frame reset.
module tb_frame_aligner_gen;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_type;
    logic        frame_detect;
    logic [7:0]  fr_byte_position;
    logic [15:0] good_frame_cnt;
    logic [15:0] lost_lock_cnt;

    int assertCount = 0;
    int failCount   = 0;

    frame_aligner_gen dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_sop          (out_sop),
        .out_eop          (out_eop),
        .out_type         (out_type),
        .frame_detect     (frame_detect),
        .fr_byte_position (fr_byte_position),
        .good_frame_cnt   (good_frame_cnt),
        .lost_lock_cnt    (lost_lock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drives one cycle and leaves the bench 1 ns after the sampling edge
    task automatic applyStimulus(input logic [7:0] d, input logic v);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] lsb, input logic [7:0] msb, input logic [7:0] base,
                             input bit fwd, input bit typ, input int nBytes, input int gapAt);
        applyStimulus(lsb, 1'b1);
        checkOutput("hdrLsbValid", 32'(out_valid), 32'd0);
        applyStimulus(msb, 1'b1);
        checkOutput("hdrMsbValid", 32'(out_valid), 32'd0);
        for (int i = 0; i < nBytes; i++) begin
            applyStimulus(base + 8'(i), 1'b1);
            checkOutput("payValid", 32'(out_valid), 32'(fwd));
            checkOutput("payPos", 32'(fr_byte_position), i);
            if (fwd) begin
                checkOutput("payData", 32'(out_data), 32'(base + 8'(i)));
                checkOutput("paySop", 32'(out_sop), 32'(i == 0));
                checkOutput("payEop", 32'(out_eop), 32'(i == 9));
                checkOutput("payType", 32'(out_type), 32'(typ));
            end
            if (i == gapAt) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(8'hEE, 1'b0);
                    checkOutput("gapValid", 32'(out_valid), 32'd0);
                    checkOutput("gapPos", 32'(fr_byte_position), i);
                    checkOutput("gapData", 32'(out_data), 32'(base + 8'(i)));
                end
            end
        end
    endtask

    task automatic sendZeros(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "Data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "Sop"}, 32'(out_sop), 32'd0);
        checkOutput({tag, "Eop"}, 32'(out_eop), 32'd0);
        checkOutput({tag, "Type"}, 32'(out_type), 32'd0);
        checkOutput({tag, "Detect"}, 32'(frame_detect), 32'd0);
        checkOutput({tag, "Pos"}, 32'(fr_byte_position), 32'd0);
        checkOutput({tag, "Good"}, 32'(good_frame_cnt), 32'd0);
        checkOutput({tag, "Lost"}, 32'(lost_lock_cnt), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset with random traffic
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        checkAllZero("rst");
        @(negedge clk);
        reset_n  = 1'b1;
        rx_valid = 1'b0;

        // Three frames to lock, none forwarded
        sendFrame(8'hAA, 8'hAF, 8'h10, 1'b0, 1'b0, 10, -1);
        sendFrame(8'hAA, 8'hAF, 8'h20, 1'b0, 1'b0, 10, -1);
        checkOutput("detectAfter2", 32'(frame_detect), 32'd0);
        sendFrame(8'hAA, 8'hAF, 8'h30, 1'b0, 1'b0, 10, -1);
        checkOutput("detectAfter3", 32'(frame_detect), 32'd1);
        checkOutput("good3", 32'(good_frame_cnt), 32'd3);

        // Fourth frame forwarded with a gap after payload byte 4
        sendFrame(8'hAA, 8'hAF, 8'h40, 1'b1, 1'b0, 10, 4);
        checkOutput("good4", 32'(good_frame_cnt), 32'd4);

        // Re-sync into a type-B frame
        applyStimulus(8'hAA, 1'b1);
        sendFrame(8'h55, 8'hBA, 8'h60, 1'b1, 1'b1, 10, -1);
        checkOutput("good5", 32'(good_frame_cnt), 32'd5);
        checkOutput("detectResync", 32'(frame_detect), 32'd1);

        // 46 junk bytes + header lsb = 47 non-aligned: lock survives
        sendZeros(46);
        checkOutput("detectRun46", 32'(frame_detect), 32'd1);
        sendFrame(8'hAA, 8'hAF, 8'h70, 1'b1, 1'b0, 10, -1);
        checkOutput("detectKept", 32'(frame_detect), 32'd1);
        checkOutput("good6", 32'(good_frame_cnt), 32'd6);

        // 48 junk bytes drop lock on the 48th
        sendZeros(47);
        checkOutput("detectAt47", 32'(frame_detect), 32'd1);
        checkOutput("lostAt47", 32'(lost_lock_cnt), 32'd0);
        sendZeros(1);
        checkOutput("detectAt48", 32'(frame_detect), 32'd0);
        checkOutput("lostAt48", 32'(lost_lock_cnt), 32'd1);

        // HLSB followed by a non-header byte clears the consecutive count
        sendFrame(8'hAA, 8'hAF, 8'h80, 1'b0, 1'b0, 10, -1);
        sendFrame(8'hAA, 8'hAF, 8'h90, 1'b0, 1'b0, 10, -1);
        checkOutput("detectRelock2", 32'(frame_detect), 32'd0);
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'h00, 1'b1);
        sendFrame(8'hAA, 8'hAF, 8'hA0, 1'b0, 1'b0, 10, -1);
        checkOutput("detectAfterClr", 32'(frame_detect), 32'd0);
        sendFrame(8'hAA, 8'hAF, 8'hB0, 1'b0, 1'b0, 10, -1);
        checkOutput("detectClr2", 32'(frame_detect), 32'd0);
        sendFrame(8'hAA, 8'hAF, 8'hC0, 1'b0, 1'b0, 10, -1);
        checkOutput("detectClr3", 32'(frame_detect), 32'd1);
        checkOutput("good11", 32'(good_frame_cnt), 32'd11);
        checkOutput("lostStill1", 32'(lost_lock_cnt), 32'd1);

        // Mid-frame reset at payload byte 5
        sendFrame(8'hAA, 8'hAF, 8'hD0, 1'b1, 1'b0, 5, -1);
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hD5;
        #1;
        checkAllZero("midRst");
        @(negedge clk);
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        sendFrame(8'hAA, 8'hAF, 8'h11, 1'b0, 1'b0, 10, -1);
        sendFrame(8'hAA, 8'hAF, 8'h21, 1'b0, 1'b0, 10, -1);
        checkOutput("postRstDetect2", 32'(frame_detect), 32'd0);
        sendFrame(8'hAA, 8'hAF, 8'h31, 1'b0, 1'b0, 10, -1);
        checkOutput("postRstDetect3", 32'(frame_detect), 32'd1);
        checkOutput("postRstGood", 32'(good_frame_cnt), 32'd3);
        checkOutput("postRstLost", 32'(lost_lock_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
